reg_bank: RTL and testbench

- General-purpose register file of the multicycle MIPS datapath; it sits directly downstream of the write-register select mux.
- That mux delivers the 5-bit destination index (rt, 29, 31 or rd) on write_reg. The write-back mux delivers write_data. The control unit drives reg_write.
- Provides two combinational read ports feeding the A/B operand registers and one synchronous write port.

---
 rtl/reg_bank.sv | 58 +++++
 tb/tb_reg_bank.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank: general-purpose register file for the multicycle MIPS datapath.
//
// Ports:
//   clk         system clock, rising-edge active
//   reset       asynchronous active-high reset
//   reg_write   write enable from the control unit
//   read_reg1   read port 1 index (rs)
//   read_reg2   read port 2 index (rt)
//   write_reg   destination index from the write-register select mux
//   write_data  write-back value
//   read_data1  regs[read_reg1], combinational
//   read_data2  regs[read_reg2], combinational
//
// Reset clears every register to zero except $sp (index 29), which loads
// SP_RESET. Register 0 reads as zero at all times and ignores writes.
// Reads are purely combinational with no write-through bypass, so a read of
// the register being written returns the old value until the clock edge.

module reg_bank #(
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          ADDR_W   = 5,
    parameter logic [DATA_W-1:0]    SP_RESET = 227
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int unsigned NREGS  = 2 ** ADDR_W;
    localparam int unsigned SP_IDX = 29;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              wr_en_d;

    // Writes to index 0 are dropped here so $zero never holds anything but 0.
    assign wr_en_d = reg_write && (write_reg != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else if (wr_en_d) begin
            regs_q[write_reg] <= write_data;
        end
    end

    // Index 0 is forced to zero on the read side as well.
    assign read_data1 = (read_reg1 == '0) ? '0 : regs_q[read_reg1];
    assign read_data2 = (read_reg2 == '0) ? '0 : regs_q[read_reg2];

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        int          port;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    logic [31:0] model [32];

    reg_bank #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .SP_RESET (32'd227)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    // Drive a read index and queue the value that port must show.
    task automatic set_rd(input int port, input logic [4:0] idx,
                          input logic [31:0] exp, input string tag);
        sb_entry_t e;
        if (port == 1) read_reg1 = idx;
        else           read_reg2 = idx;
        e.tag  = tag;
        e.port = port;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Let combinational reads settle, then drain the scoreboard.
    task automatic settle();
        sb_entry_t   e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = (e.port == 1) ? read_data1 : read_data2;
            checks++;
            assert (obs === e.exp)
            else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic drive_write(input logic we, input logic [4:0] a,
                               input logic [31:0] d);
        reg_write  = we;
        write_reg  = a;
        write_data = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        reg_write  = 1'b0;
        read_reg1  = '0;
        read_reg2  = '0;
        write_reg  = '0;
        write_data = '0;

        // 1. Reset pulse before any clk edge, then sweep read port 1.
        #5 reset = 1'b1;
        set_rd(1, 5'd29, 32'd227, "reset_hold_sp");
        set_rd(2, 5'd0,  32'd0,   "reset_hold_zero");
        settle();
        #2 reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            set_rd(1, 5'(i), (i == 29) ? 32'd227 : 32'd0,
                   $sformatf("reset_sweep_%0d", i));
            settle();
        end

        // 2. Basic write to $8.
        @(negedge clk);
        drive_write(1'b1, 5'd8, 32'hDEADBEEF);
        set_rd(2, 5'd8, 32'd0, "wr8_before_edge");
        settle();
        step();
        reg_write = 1'b0;
        set_rd(2, 5'd8, 32'hDEADBEEF, "wr8_after_edge");
        settle();

        // 3. Writes to $0 are discarded.
        @(negedge clk);
        drive_write(1'b1, 5'd0, 32'hFFFFFFFF);
        step();
        reg_write = 1'b0;
        set_rd(1, 5'd0, 32'd0, "zero_rd1");
        set_rd(2, 5'd0, 32'd0, "zero_rd2");
        settle();

        // 4. $sp and $ra writes, then a disabled write to $sp.
        @(negedge clk);
        drive_write(1'b1, 5'd29, 32'h000000E0);
        step();
        drive_write(1'b1, 5'd31, 32'h00000044);
        step();
        reg_write = 1'b0;
        set_rd(1, 5'd29, 32'h000000E0, "sp_write");
        set_rd(2, 5'd31, 32'h00000044, "ra_write");
        settle();
        @(negedge clk);
        drive_write(1'b0, 5'd29, 32'h00000001);
        step();
        set_rd(1, 5'd29, 32'h000000E0, "sp_no_we");
        settle();

        // 5. Read-during-write on $5: old value before the edge, new after.
        @(negedge clk);
        drive_write(1'b1, 5'd5, 32'h00000010);
        step();
        reg_write = 1'b0;
        @(negedge clk);
        drive_write(1'b1, 5'd5, 32'h00000020);
        set_rd(1, 5'd5, 32'h00000010, "rdw_old_p1");
        set_rd(2, 5'd5, 32'h00000010, "rdw_old_p2");
        settle();
        step();
        reg_write = 1'b0;
        set_rd(1, 5'd5, 32'h00000020, "rdw_new_p1");
        set_rd(2, 5'd5, 32'h00000020, "rdw_new_p2");
        settle();

        // 6. Asynchronous reset mid-cycle during a pending write.
        @(negedge clk);
        drive_write(1'b1, 5'd5, 32'h00000099);
        #40 reset = 1'b1;
        set_rd(1, 5'd5,  32'd0,   "midrst_r5");
        set_rd(2, 5'd29, 32'd227, "midrst_sp");
        settle();
        step();
        set_rd(1, 5'd5, 32'd0, "rst_blocks_write");
        set_rd(2, 5'd8, 32'd0, "rst_clears_r8");
        settle();
        @(negedge clk);
        reset     = 1'b0;
        reg_write = 1'b0;
        step();
        set_rd(1, 5'd5,  32'd0,   "post_rst_r5");
        set_rd(2, 5'd31, 32'd0,   "post_rst_ra");
        settle();

        // Fill every register with a distinct pattern and read it back on
        // both ports, port 2 walking the indices in reverse.
        for (int i = 0; i < 32; i++) begin
            model[i] = (i == 0) ? 32'd0 : (32'hA5000000 | (32'(i) * 32'h00010203));
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive_write(1'b1, 5'(i), 32'hA5000000 | (32'(i) * 32'h00010203));
            step();
        end
        reg_write = 1'b0;
        for (int i = 0; i < 32; i++) begin
            set_rd(1, 5'(i),      model[i],      $sformatf("fill_p1_%0d", i));
            set_rd(2, 5'(31 - i), model[31 - i], $sformatf("fill_p2_%0d", 31 - i));
            settle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
